// File: rtl/uart_rx_if.sv
// Byte-stream output bundle of the UART receiver.
// UART_RX_FRAME_ERR_EN adds the frame_err strobe.
interface uart_rx_if;
    logic [7:0] axiid;
    logic       axiiv;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;

    modport master (output axiid, output axiiv, output frame_err);
    modport slave  (input axiid, input axiiv, input frame_err);
`else
    modport master (output axiid, output axiiv);
    modport slave  (input axiid, input axiiv);
`endif
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a 2-flop input synchroniser.
// Optional UART_RX_FRAME_ERR_EN adds a frame_err strobe on a bad stop bit.
module uart_rx #(
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int CW = $clog2(CLOCKS_PER_BAUD) + 1;
    localparam logic [CW-1:0] FULL = CW'(CLOCKS_PER_BAUD);
    localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_BAUD / 2);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    axiid_q;
    logic          axiiv_q;
    logic          sync1_q;
    logic          rx_s;
`ifdef UART_RX_FRAME_ERR_EN
    logic          ferr_q;
`endif

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s    <= sync1_q;
        end
    end

    // Frame state machine: counter restarts at each sample point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            axiid_q <= '0;
            axiiv_q <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            ferr_q  <= 1'b0;
`endif
        end else begin
            axiiv_q <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            ferr_q  <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        cnt_q   <= ONE;
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == HALF) begin
                        cnt_q   <= ONE;
                        bit_q   <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL) begin
                        cnt_q   <= ONE;
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            axiid_q <= shift_q;
                            axiiv_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
`ifdef UART_RX_FRAME_ERR_EN
                            ferr_q  <= 1'b1;
`endif
                            state_q <= BRK;
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.axiid = axiid_q;
    assign bus.axiiv = axiiv_q;
`ifdef UART_RX_FRAME_ERR_EN
    assign bus.frame_err = ferr_q;
`endif

endmodule
